ahb_mem_arbiter: RTL and testbench

- Master-side controller for the ahb_inte memory slave.
- Shares the single AHB port between an instruction-fetch requester (IF) and a load/store requester (LS).
- Sequences each access through the address phase and the data phase, and returns read data and error status to the requester that was granted.
- One transfer outstanding at a time; fixed LS priority with an IF starvation guard.

---
 rtl/ahb_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ahb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: shares one AHB master port between instruction fetch (IF) and load/store (LS).
// Latency: grant in cycle 0, address phase in cycle 1, data phase from cycle 2, rvalid one cycle after hready.
// Backpressure: one transfer outstanding; grants only in IDLE; data phase stalls on hready low.
// Optional macro HREADY_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES consecutive hready-low data cycles.
module ahb_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4
`ifdef HREADY_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // load/store requester
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_size,
  input  logic        ls_signed,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  // AHB master port
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [31:0] hwdata,
  output logic        is_signed,
  output logic [1:0]  htrans,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_MERR = 2'd3
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t      state;
  logic [SW-1:0] starve_cnt;
  logic        starve_hit;
  logic        owner_ls;     // 1 = current transfer belongs to LS
  logic [31:0] wdata_q;      // store data held until the data phase
  logic        ls_illegal;
  logic        data_done;
  logic        done_err;
  logic [31:0] done_rdata;

`ifdef HREADY_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // IF wins contention only once it has lost STARVE_LIMIT arbitrations in a row
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign ls_gnt     = (state == S_IDLE) && ls_req && !(if_req && starve_hit);
  assign if_gnt     = (state == S_IDLE) && if_req && (!ls_req || starve_hit);

  // Misaligned or unsupported LS sizes never reach the bus
  assign ls_illegal = (ls_size > 3'b010) ||
                      ((ls_size == 3'b001) && ls_addr[0]) ||
                      ((ls_size == 3'b010) && (ls_addr[1:0] != 2'b00));

  // Decide whether the data phase ends this cycle and with what result
  always_comb begin
    data_done  = 1'b0;
    done_err   = hresp;
    done_rdata = hresp ? 32'h0 : hrdata;
    if (hready) begin
      data_done = 1'b1;
    end
`ifdef HREADY_TIMEOUT_EN
    else if (to_hit) begin
      data_done  = 1'b1;
      done_err   = 1'b1;
      done_rdata = 32'h0;
    end
`endif
  end

  // Starvation counter: counts IF losses to LS while IF keeps requesting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (ls_gnt && !starve_hit) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Transfer sequencer: grant, address phase, data phase, completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner_ls  <= 1'b0;
      wdata_q   <= 32'h0;
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
      if_err    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= 32'h0;
      ls_err    <= 1'b0;
      haddr     <= 32'h0;
      hwrite    <= 1'b0;
      hsize     <= 3'b000;
      hprot     <= 4'b0000;
      hwdata    <= 32'h0;
      is_signed <= 1'b0;
      htrans    <= 2'b00;
`ifdef HREADY_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        S_IDLE: begin
          htrans    <= 2'b00;
          haddr     <= 32'h0;
          hwrite    <= 1'b0;
          hsize     <= 3'b000;
          hprot     <= 4'b0000;
          hwdata    <= 32'h0;
          is_signed <= 1'b0;
          if (ls_gnt) begin
            owner_ls <= 1'b1;
            wdata_q  <= ls_wdata;
            if (ls_illegal) begin
              state <= S_MERR;
            end else begin
              state     <= S_ADDR;
              htrans    <= 2'b10;
              haddr     <= ls_addr;
              hwrite    <= ls_we;
              hsize     <= ls_size;
              hprot     <= 4'b0011;
              is_signed <= ls_signed;
            end
          end else if (if_gnt) begin
            owner_ls  <= 1'b0;
            state     <= S_ADDR;
            htrans    <= 2'b10;
            haddr     <= if_addr;
            hwrite    <= 1'b0;
            hsize     <= 3'b010;
            hprot     <= 4'b0010;
            is_signed <= 1'b0;
          end
        end
        S_ADDR: begin
          // address and control stay held; only stores drive write data
          htrans <= 2'b00;
          hwdata <= hwrite ? wdata_q : 32'h0;
          state  <= S_DATA;
`ifdef HREADY_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        S_DATA: begin
          if (data_done) begin
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= done_rdata;
              ls_err    <= done_err;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= done_rdata;
              if_err    <= done_err;
            end
            haddr     <= 32'h0;
            hwrite    <= 1'b0;
            hsize     <= 3'b000;
            hprot     <= 4'b0000;
            hwdata    <= 32'h0;
            is_signed <= 1'b0;
            state     <= S_IDLE;
          end
`ifdef HREADY_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        S_MERR: begin
          // rejected LS access: report the error without touching the bus
          ls_rvalid <= 1'b1;
          ls_err    <= 1'b1;
          ls_rdata  <= 32'h0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_ahb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we, ls_signed;
  logic [31:0] ls_addr, ls_wdata;
  logic [2:0]  ls_size;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, is_signed, hready, hresp;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ahb_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_size(ls_size), .ls_signed(ls_signed), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .is_signed(is_signed), .htrans(htrans), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        sgn;
    int          waits;    // hready-low data cycles before the ready cycle
    logic        resp;
    logic [31:0] rdat;
    logic        merr;     // expected to be rejected without bus activity
    logic [3:0]  e_hprot;
    logic [2:0]  e_hsize;
    logic [31:0] e_hwdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
    chk({tag, "_haddr"}, haddr, 32'd0);
    chk({tag, "_ctrl"}, {hwrite, hsize, hprot, is_signed}, 32'd0);
    chk({tag, "_hwdata"}, hwdata, 32'd0);
    chk({tag, "_rvalid"}, {if_rvalid, ls_rvalid}, 32'd0);
    chk({tag, "_rdata"}, if_rdata | ls_rdata, 32'd0);
    chk({tag, "_err"}, {if_err, ls_err}, 32'd0);
  endtask

  // One transaction from a table record, checked phase by phase
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    if (v.is_ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
      ls_size = v.size; ls_signed = v.sgn;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    #1;
    chk({t, "_gnt"}, v.is_ls ? ls_gnt : if_gnt, 32'd1);
    chk({t, "_other_gnt"}, v.is_ls ? if_gnt : ls_gnt, 32'd0);
    tick();
    ls_req = 1'b0; if_req = 1'b0;
    if (v.merr) begin
      chk({t, "_merr_htrans"}, {30'd0, htrans}, 32'd0);
      chk({t, "_merr_rvalid"}, {31'd0, ls_rvalid}, 32'd0);
    end else begin
      chk({t, "_addr_htrans"}, {30'd0, htrans}, 32'd2);
      chk({t, "_addr_haddr"}, haddr, v.addr);
      chk({t, "_addr_ctrl"}, {hwrite, hsize, hprot, is_signed},
          {23'd0, v.is_ls & v.we, v.e_hsize, v.e_hprot, v.is_ls & v.sgn});
      hready = (v.waits == 0); hresp = v.resp; hrdata = v.rdat;
      tick();
      chk({t, "_data_htrans"}, {30'd0, htrans}, 32'd0);
      chk({t, "_data_hwdata"}, hwdata, v.e_hwdata);
      chk({t, "_data_haddr"}, haddr, v.addr);
      for (int k = 0; k < v.waits; k++) begin
        tick();
        chk({t, "_wait_rvalid"}, {if_rvalid, ls_rvalid}, 32'd0);
        hready = (k == v.waits - 1);
      end
    end
    tick();
    hready = 1'b1; hresp = 1'b0;
    chk({t, "_rvalid"}, v.is_ls ? ls_rvalid : if_rvalid, 32'd1);
    chk({t, "_other_rvalid"}, v.is_ls ? if_rvalid : ls_rvalid, 32'd0);
    chk({t, "_rdata"}, v.is_ls ? ls_rdata : if_rdata, v.e_rdata);
    chk({t, "_err"}, v.is_ls ? ls_err : if_err, {31'd0, v.e_err});
    chk({t, "_idle_bus"}, {haddr[30:0], htrans}, 33'd0);
    tick();
    chk({t, "_pulse_end"}, {if_rvalid, ls_rvalid}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 0);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [9:0] order;
    logic [9:0] exp_order;
    logic       seen;
    int         got;

    //        is_ls we addr          wdata         size  sgn w resp rdat          merr hprot    hsize   hwdata        rdata         err
    vt[0] = '{1'b1, 1'b1, 32'h04,  32'hA5A5A5A5, 3'b010, 1'b0, 0, 1'b0, 32'h0,        1'b0, 4'b0011, 3'b010, 32'hA5A5A5A5, 32'h0,        1'b0};
    vt[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        3'b010, 1'b0, 3, 1'b0, 32'h00000013, 1'b0, 4'b0010, 3'b010, 32'h0,        32'h00000013, 1'b0};
    vt[2] = '{1'b1, 1'b0, 32'h02,  32'h0,        3'b001, 1'b1, 1, 1'b0, 32'hFFFF8001, 1'b0, 4'b0011, 3'b001, 32'h0,        32'hFFFF8001, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h03,  32'h55,       3'b000, 1'b0, 0, 1'b0, 32'h0000007F, 1'b0, 4'b0011, 3'b000, 32'h0,        32'h0000007F, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h06,  32'h0,        3'b010, 1'b0, 0, 1'b0, 32'h0,        1'b1, 4'b0000, 3'b000, 32'h0,        32'h0,        1'b1};
    vt[5] = '{1'b1, 1'b1, 32'h01,  32'h1234,     3'b001, 1'b0, 0, 1'b0, 32'h0,        1'b1, 4'b0000, 3'b000, 32'h0,        32'h0,        1'b1};
    vt[6] = '{1'b1, 1'b0, 32'h00,  32'h0,        3'b011, 1'b0, 0, 1'b0, 32'h0,        1'b1, 4'b0000, 3'b000, 32'h0,        32'h0,        1'b1};
    vt[7] = '{1'b1, 1'b0, 32'h20,  32'h0,        3'b010, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 4'b0011, 3'b010, 32'h0,        32'h0,        1'b1};
    vt[8] = '{1'b0, 1'b0, 32'h104, 32'h0,        3'b010, 1'b0, 2, 1'b1, 32'hCAFEF00D, 1'b0, 4'b0010, 3'b010, 32'h0,        32'h0,        1'b1};

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = 32'h0; ls_wdata = 32'h0; ls_size = 3'b000; ls_signed = 1'b0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    tick(); tick(); tick();
    chk_all_zero("reset");
    chk("reset_gnt", {if_gnt, ls_gnt}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_htrans", {30'd0, htrans}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

    // Contention: both held high, IF must win every fifth arbitration
    if_req = 1'b1; if_addr = 32'h200;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h10; ls_size = 3'b010; ls_signed = 1'b0;
    hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    #1;
    got = 0; order = '0; exp_order = 10'h210;
    for (int c = 0; c < 200 && got < 10; c++) begin
      if (if_gnt || ls_gnt) begin
        order[got] = if_gnt;
        got++;
      end
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("contention_grants", got, 32'd10);
    chk("contention_order", {22'd0, order}, {22'd0, exp_order});
    for (int c = 0; c < 6; c++) tick();
    chk("contention_drained", {30'd0, htrans}, 32'd0);

    // Reset while a load sits in the data phase
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h08; ls_size = 3'b010;
    hready = 1'b0;
    #1;
    chk("rst_mid_gnt", {31'd0, ls_gnt}, 32'd1);
    tick();
    ls_req = 1'b0;
    tick();
    chk("rst_mid_in_data", haddr, 32'h08);
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_mid1");
    tick();
    chk_all_zero("rst_mid2");
    rst_n = 1'b1; hready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if_rvalid || ls_rvalid) seen = 1'b1;
    end
    chk("rst_mid_no_rvalid", {31'd0, seen}, 32'd0);

    // hready stuck low in the data phase
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; ls_size = 3'b010;
    hready = 1'b0; hrdata = 32'h00001234;
    #1;
    chk("to_gnt", {31'd0, ls_gnt}, 32'd1);
    tick();
    ls_req = 1'b0;
    tick();
    seen = 1'b0;
`ifdef HREADY_TIMEOUT_EN
    for (int d = 1; d <= 16; d++) begin
      if (ls_rvalid || if_rvalid) seen = 1'b1;
      tick();
    end
    chk("to_early_rvalid", {31'd0, seen}, 32'd0);
    chk("to_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("to_err", {31'd0, ls_err}, 32'd1);
    chk("to_rdata", ls_rdata, 32'h0);
    hready = 1'b1;
    tick();
    chk("to_idle", haddr, 32'h0);
`else
    for (int c = 2; c < 40; c++) begin
      if (ls_rvalid || if_rvalid) seen = 1'b1;
      tick();
    end
    chk("to_no_rvalid", {31'd0, seen | ls_rvalid}, 32'd0);
    chk("to_still_data", haddr, 32'h40);
    hready = 1'b1;
    tick();
    chk("to_late_rvalid", {31'd0, ls_rvalid}, 32'd1);
    chk("to_late_rdata", ls_rdata, 32'h00001234);
    chk("to_late_err", {31'd0, ls_err}, 32'd0);
    tick();
`endif
    chk("final_pulse_end", {30'd0, if_rvalid, ls_rvalid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
